// File: rtl/paral_serial_pkg.sv
// Shared types and constants for the paral_serial converter.
package paral_serial_pkg;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SYNC_W = 4;

   localparam logic [WORD_W-1:0] COMMA_DEFAULT      = 8'hBC;
   localparam int unsigned       SYNC_WORDS_DEFAULT = 4;

   typedef enum logic {
      SYNC   = 1'b0,
      ACTIVE = 1'b1
   } ps_state_e;

endpackage

// File: rtl/ps_bit_counter.sv
// Bit position counter for paral_serial: 3-bit wrap counter, sync active-low clear.
module ps_bit_counter
   import paral_serial_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             enb,
   output logic [CNT_W-1:0] count,
   output logic             load
);

   // Advance one bit position per enabled cycle, wrapping 7 -> 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (enb) begin
         count <= count + CNT_W'(1);
      end
   end

   assign load = (count == '0);

endmodule

// File: rtl/paral_serial.sv
// Parallel-to-serial converter: comma sync, then ready/valid-loaded data words.
// Build option: define PARAL_SERIAL_LSB_FIRST_EN to send bit0 first (default bit7 first).
module paral_serial
   import paral_serial_pkg::*;
#(
   parameter logic [WORD_W-1:0] COMMA      = COMMA_DEFAULT,
   parameter int unsigned       SYNC_WORDS = SYNC_WORDS_DEFAULT
) (
   input  logic              clk_8f,
   input  logic              rst,
   input  logic              enb,
   input  logic [WORD_W-1:0] data_in,
   input  logic              valid_in,
   output logic              data_ready,
   output logic              data_out,
   output logic              active
);

   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_WORDS - 1);

   logic [CNT_W-1:0]  bit_cnt;
   logic              load;
   ps_state_e         state, state_nxt;
   logic [SYNC_W-1:0] sync_cnt, sync_cnt_nxt;
   logic [WORD_W-1:0] shreg, shreg_nxt;
   logic [WORD_W-1:0] word;
   logic              data_out_nxt;
   logic              active_nxt;

   ps_bit_counter u_bit_counter (
      .clk   (clk_8f),
      .rst   (rst),
      .enb   (enb),
      .count (bit_cnt),
      .load  (load)
   );

   // Upstream may hand over a word only on an enabled load cycle in ACTIVE.
   assign data_ready = rst && enb && (state == ACTIVE) && (bit_cnt == '0);

   // Word chosen at a load edge: data when offered in ACTIVE, comma otherwise.
   assign word = ((state == ACTIVE) && valid_in) ? data_in : COMMA;

   // State, sync counter, shift register and serial output registers.
   always_ff @(posedge clk_8f) begin
      if (!rst) begin
         state    <= SYNC;
         sync_cnt <= '0;
         shreg    <= '0;
         data_out <= 1'b0;
         active   <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync_cnt <= sync_cnt_nxt;
         shreg    <= shreg_nxt;
         data_out <= data_out_nxt;
         active   <= active_nxt;
      end
   end

   // Next-state: load/shift the serialiser and walk the sync phase.
   always_comb begin
      state_nxt    = state;
      sync_cnt_nxt = sync_cnt;
      shreg_nxt    = shreg;
      data_out_nxt = data_out;
      active_nxt   = active;
      if (enb) begin
         if (load) begin
`ifdef PARAL_SERIAL_LSB_FIRST_EN
            data_out_nxt = word[0];
            shreg_nxt    = word >> 1;
`else
            data_out_nxt = word[WORD_W-1];
            shreg_nxt    = word << 1;
`endif
            if (state == SYNC) begin
               sync_cnt_nxt = sync_cnt + SYNC_W'(1);
               // The word loaded on this edge is still a comma.
               if (sync_cnt == SYNC_LAST) begin
                  state_nxt  = ACTIVE;
                  active_nxt = 1'b1;
               end
            end
         end else begin
`ifdef PARAL_SERIAL_LSB_FIRST_EN
            data_out_nxt = shreg[0];
            shreg_nxt    = shreg >> 1;
`else
            data_out_nxt = shreg[WORD_W-1];
            shreg_nxt    = shreg << 1;
`endif
         end
      end
   end

endmodule
